// File: rtl/sap_pkg.sv
// sap_pkg: shared widths, halt opcode and fetch-state encoding for the SAP fetch path.
package sap_pkg;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam logic [3:0] HLT_OPCODE = 4'hF;
    typedef enum logic [2:0] {IDLE, ADDR, READ, HOLD, HALT} fetch_state_t;
endpackage

// File: rtl/register_nbit.sv
// register_nbit: N-bit load-enabled register with synchronous active-high reset.
module register_nbit #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    always_ff @(posedge clk)
        if (reset) q <= '0;
        else if (load) q <= d;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM feeding the instruction register from a sync program RAM,
// with decode handshake, jump redirect and halt-on-HLT.
module fetch_unit
    import sap_pkg::*;
#(
    parameter int ADDR_W = sap_pkg::ADDR_W,
    parameter int DATA_W = sap_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted
);
    fetch_state_t state;
    logic [ADDR_W-1:0] pc;
    register_nbit #(.N(DATA_W)) u_ir (
        .clk  (clk),
        .reset(reset),
        .load (state == READ && !jump_en),
        .d    (mem_rdata),
        .q    (instr)
    );
    // A jump outranks both the handshake and HLT detection; only HALT ignores it.
    always_ff @(posedge clk)
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            instr_valid <= 1'b0;
        end else if (jump_en && state != HALT) begin
            pc          <= jump_addr;
            instr_valid <= 1'b0;
            state       <= ADDR;
        end else begin
            case (state)
                IDLE: state <= ADDR;
                ADDR: state <= READ;
                READ: begin
                    instr_valid <= 1'b1;
                    pc          <= pc + ADDR_W'(1);
                    state       <= HOLD;
                end
                HOLD: if (instr_valid && instr_ready) begin
                    instr_valid <= 1'b0;
                    state       <= instr[7:4] == HLT_OPCODE ? HALT : ADDR;
                end
                default: state <= HALT;
            endcase
        end
    assign mem_addr = pc;
    assign pc_out   = pc;
    assign mem_rd   = state == ADDR;
    assign halted   = state == HALT;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a randomized run scored against an address-stream model.
module tb_fetch_unit;
    logic       clk = 1'b0, reset = 1'b1;
    logic       mem_rd, instr_valid, halted;
    logic       instr_ready = 1'b0, jump_en = 1'b0;
    logic [3:0] mem_addr, pc_out, jump_addr = 4'h0;
    logic [7:0] mem_rdata = 8'h00, instr;
    logic [7:0] ram [16];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .jump_en(jump_en), .jump_addr(jump_addr),
        .pc_out(pc_out), .halted(halted)
    );

    always @(posedge clk) if (mem_rd) mem_rdata <= ram[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b1;
        jump_en = 1'b0;
        step();
        chk(tag, {pc_out, instr, instr_valid, halted, mem_rd, mem_addr}, {4'h0, 8'h00, 3'b000, 4'h0});
        reset = 1'b0;
    endtask

    task automatic fetch_tail(input string tag, input logic [7:0] ei, input logic [3:0] ep);
        step();
        chk({tag, "_read"}, {31'd0, instr_valid}, 0);
        step();
        chk({tag, "_hold"}, {instr_valid, instr, pc_out}, {1'b1, ei, ep});
    endtask

    task automatic expect_fetch(input string tag, input logic [7:0] ei, input logic [3:0] ep);
        step();
        chk({tag, "_first"}, {31'd0, instr_valid}, 0);
        fetch_tail(tag, ei, ep);
    endtask

    initial begin
        logic [3:0] exp_addr;
        logic [7:0] prev_instr;
        logic       hold_prev;
        int         delivered;
        for (int i = 0; i < 16; i++) ram[i] = 8'($urandom_range(0, 8'hEF));
        ram[0] = 8'h1A; ram[1] = 8'h2B; ram[2] = 8'hF0; ram[15] = 8'h11;

        // three-instruction program ending in HLT, ready held high
        instr_ready = 1'b1;
        apply_reset("reset_initial");
        for (int n = 1; n <= 12; n++) begin
            step();
            chk("prog_valid", {31'd0, instr_valid}, {31'd0, n == 3 || n == 6 || n == 9});
            chk("prog_mem_rd", {31'd0, mem_rd}, {31'd0, n == 1 || n == 4 || n == 7});
            chk("prog_halted", {31'd0, halted}, {31'd0, n >= 10});
            if (n == 3) chk("prog_i0", instr, 8'h1A);
            if (n == 6) chk("prog_i1", instr, 8'h2B);
            if (n == 9) chk("prog_i2", instr, 8'hF0);
        end
        chk("prog_pc", pc_out, 4'h3);
        jump_en = 1'b1; jump_addr = 4'h5;
        for (int n = 0; n < 2; n++) begin
            step();
            chk("halt_ignores_jump", {halted, mem_rd, pc_out}, {2'b10, 4'h3});
        end
        jump_en = 1'b0;

        // reset out of HALT, then stall decode for five cycles
        instr_ready = 1'b0;
        apply_reset("reset_in_halt");
        expect_fetch("after_halt_reset", 8'h1A, 4'h1);
        for (int n = 0; n < 5; n++) begin
            step();
            chk("stall", {instr_valid, instr, pc_out, mem_rd}, {1'b1, 8'h1A, 4'h1, 1'b0});
        end

        // reset while holding an instruction
        instr_ready = 1'b1;
        apply_reset("reset_in_hold");
        instr_ready = 1'b0;
        expect_fetch("after_hold_reset", 8'h1A, 4'h1);

        // jump during READ discards the in-flight fetch
        instr_ready = 1'b1;
        step();
        chk("j_addr_state", {mem_rd, mem_addr, instr_valid}, {1'b1, 4'h1, 1'b0});
        instr_ready = 1'b0;
        step();
        chk("j_read_state", {mem_rd, instr_valid}, {2'b00});
        jump_en = 1'b1; jump_addr = 4'hE;
        step();
        chk("j_redirect", {mem_rd, mem_addr, pc_out, instr_valid, instr}, {1'b1, 4'hE, 4'hE, 1'b0, 8'h1A});
        jump_en = 1'b0;
        fetch_tail("j_target", ram[14], 4'hF);

        // jump in HOLD (over a ready handshake) to F, then wrap to 0
        jump_en = 1'b1; jump_addr = 4'hF; instr_ready = 1'b1;
        step();
        chk("jF_redirect", {mem_rd, mem_addr, instr_valid}, {1'b1, 4'hF, 1'b0});
        jump_en = 1'b0; instr_ready = 1'b0;
        fetch_tail("wrap_fetch", 8'h11, 4'h0);
        instr_ready = 1'b1;
        step();
        chk("wrap_next_addr", {mem_rd, mem_addr}, {1'b1, 4'h0});
        instr_ready = 1'b0;
        fetch_tail("wrap_next", 8'h1A, 4'h1);

        // jump coincident with an HLT handshake must not halt
        jump_en = 1'b1; jump_addr = 4'h2;
        step();
        chk("to_hlt_addr", {mem_rd, mem_addr}, {1'b1, 4'h2});
        jump_en = 1'b0;
        fetch_tail("hlt_fetch", 8'hF0, 4'h3);
        jump_en = 1'b1; jump_addr = 4'h1; instr_ready = 1'b1;
        step();
        chk("hlt_jump", {halted, mem_rd, mem_addr, instr_valid}, {2'b01, 4'h1, 1'b0});
        jump_en = 1'b0; instr_ready = 1'b0;
        fetch_tail("hlt_jump_target", 8'h2B, 4'h2);
        chk("hlt_jump_not_halted", {31'd0, halted}, 0);

        // randomized run: every delivered instruction must follow the fetch-address stream
        for (int i = 0; i < 16; i++) ram[i] = 8'($urandom_range(0, 8'hEF));
        instr_ready = 1'b0;
        apply_reset("reset_random");
        exp_addr = 4'h0; hold_prev = 1'b0; prev_instr = 8'h00; delivered = 0;
        for (int n = 0; n < 600; n++) begin
            step();
            chk("rnd_not_halted", {31'd0, halted}, 0);
            if (mem_rd) chk("rnd_rd_addr", {mem_addr, instr_valid}, {pc_out, 1'b0});
            if (hold_prev) chk("rnd_stable", {instr_valid, instr}, {1'b1, prev_instr});
            jump_en = $urandom_range(0, 9) == 0;
            jump_addr = 4'($urandom_range(0, 15));
            instr_ready = 1'($urandom_range(0, 1));
            hold_prev = 1'b0;
            if (jump_en) exp_addr = jump_addr;
            else if (instr_valid && instr_ready) begin
                chk("rnd_instr", instr, ram[exp_addr]);
                chk("rnd_pc", pc_out, 4'(exp_addr + 4'd1));
                exp_addr = exp_addr + 4'd1;
                delivered++;
            end else begin
                hold_prev = instr_valid;
                prev_instr = instr;
            end
        end
        jump_en = 1'b0; instr_ready = 1'b0;
        chk("rnd_deliveries", {31'd0, delivered >= 30}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, program-memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, instruction width.
REQ-003 SHALL have port clk, input, 1, clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port mem_addr, output, ADDR_W, program RAM address, always equal to pc.
REQ-006 SHALL have port mem_rd, output, 1, RAM read strobe, high only in state ADDR.
REQ-007 SHALL have port mem_rdata, input, DATA_W, RAM read data, valid one cycle after mem_rd.
REQ-008 SHALL have port instr, output, DATA_W, fetched instruction to the instruction register.
REQ-009 SHALL have port instr_valid, output, 1, instr holds an unconsumed instruction.
REQ-010 SHALL have port instr_ready, input, 1, the decode stage accepts instr this cycle.
REQ-011 SHALL have port jump_en, input, 1, redirect fetch.
REQ-012 SHALL have port jump_addr, input, ADDR_W, redirect target.
REQ-013 SHALL have port pc_out, output, ADDR_W, current pc, for debug and bus display.
REQ-014 SHALL have port halted, output, 1, high while in state HALT.

Function
REQ-015 SHALL implement the states IDLE, ADDR, READ, HOLD and HALT, registered.
REQ-016 IDLE SHALL go unconditionally to ADDR on the next cycle.
REQ-017 ADDR SHALL assert mem_rd with mem_addr=pc, then go to READ.
REQ-018 READ SHALL register instr<=mem_rdata, set instr_valid<=1 and pc<=pc+1, then go to HOLD.
REQ-019 pc increment SHALL wrap modulo 2^ADDR_W, so 4'hF goes to 4'h0; no flag is produced.
REQ-020 HOLD SHALL keep instr and instr_valid stable until instr_valid&&instr_ready.
REQ-021 On a HOLD handshake the block SHALL clear instr_valid and go to ADDR.
REQ-022 Exception to REQ-021: if instr[7:4]==HLT_OPCODE at the handshake, the block SHALL go to HALT instead.
REQ-023 HALT SHALL be left only by reset; jump_en and instr_ready SHALL be ignored there.
REQ-024 jump_en in ADDR, READ or HOLD SHALL set pc<=jump_addr, clear instr_valid and go to ADDR.
REQ-025 jump_en SHALL have priority over the handshake and over HLT detection.
REQ-026 A READ-cycle jump SHALL discard mem_rdata, leaving instr unchanged and instr_valid low.
REQ-027 jump_en in IDLE SHALL load pc<=jump_addr; the block SHALL then go to ADDR as normal.
REQ-028 Latency from reset deassertion to the first instr_valid SHALL be 3 cycles (IDLE, ADDR, READ).
REQ-029 Throughput SHALL be one instruction per 3 cycles with instr_ready held high.
REQ-030 mem_rd SHALL never be high in IDLE, READ, HOLD or HALT.

Reset
REQ-031 While reset is high the outputs SHALL be: state IDLE, pc=0, instr=0, instr_valid=0, halted=0, mem_rd=0.
REQ-032 Reset mid-fetch or in HALT SHALL abandon the operation, and fetch SHALL restart from address 0.

Structure
REQ-033 Shared package sap_pkg SHALL hold ADDR_W, DATA_W, HLT_OPCODE=4'hF and the fetch-state enumeration.
REQ-034 The instruction holding register SHALL be an instance of the existing register_nbit with N=DATA_W.
REQ-035 The register_nbit load for that instance SHALL be (state==READ)&&!jump_en.
REQ-036 The pc and the FSM SHALL be inline; no other sub-module.

Verification
REQ-037 Bench SHALL use a sync RAM model preloaded 0:8'h1A, 1:8'h2B, 2:8'hF0, with instr_ready=1 -> instr_valid in cycles 3, 6, 9 with 1A, 2B, F0; halted=1 afterwards; pc_out=3.
REQ-038 Bench SHALL hold instr_ready=0 for 5 cycles with instr=8'h1A valid -> instr, instr_valid and pc_out=1 stable; mem_rd=0 throughout.
REQ-039 Bench SHALL pulse jump_en with jump_addr=4'hE in a READ cycle -> no instr_valid for that fetch; next mem_addr=E; RAM[E] delivered.
REQ-040 Bench SHALL start at pc=4'hF via jump, with RAM[F]=8'h11 -> instr=11 delivered, pc_out wraps to 0, next fetch from address 0.
REQ-041 Bench SHALL assert jump_en in the same cycle as an HLT handshake -> no HALT; fetch from jump_addr.
REQ-042 Bench SHALL assert reset for 1 cycle while in HOLD and while in HALT -> outputs per REQ-031; first instr_valid 3 cycles after reset falls, fetched from address 0.
